te_connector: RTL and testbench
===============================

Name: te_connector

Overview:
- Converts CVA6 commit-stage retirement information into the single-lane instruction-block interface consumed by the RISC-V E-trace encoder (rv_tracer).
- Buffers up to NRET retired instructions per cycle plus trap events in a FIFO.
- Pops one entry per cycle and merges consecutive inferable instructions into blocks.
- Emits one block per discontinuity (branch, uninferable jump, return, trap) or per counter saturation.

Parameters:
- NRET, 2, commit ports per cycle (1..4).
- FIFO_DEPTH, 16, internal entry FIFO depth; power of 2, at least NRET+1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- valid_i  in  NRET  slot retires an instruction; slot 0 is oldest.
- pc_i  in  NRET x XLEN  per-slot instruction address.
- op_i  in  NRET x OP_LEN  per-slot op_class_e.
- is_compressed_i  in  NRET  per-slot 16-bit instruction flag.
- branch_valid_i  in  1  branch outcome valid this cycle; applies to the single OP_BRANCH slot.
- is_taken_i  in  1  branch taken.
- ex_valid_i  in  1  trap this cycle, ordered after all valid slots.
- cause_i  in  XLEN  trap cause; MSB=1 means interrupt.
- tval_i  in  XLEN  trap value.
- priv_lvl_i  in  PRIV_LEN  current privilege.
- valid_o  out  1  block valid, one-cycle pulse.
- iretire_o  out  IRETIRE_LEN  halfwords retired in block.
- ilastsize_o  out  1  last instruction 32-bit=1, 16-bit=0.
- itype_o  out  ITYPE_LEN  block termination type.
- cause_o, tval_o  out  XLEN  trap info, zero for non-trap blocks.
- priv_o  out  PRIV_LEN  privilege of the terminating entry.
- iaddr_o  out  XLEN  address of first instruction in block.
- overflow_o  out  1  sticky, set when entries are dropped.

Behaviour:
- Reset (rst_i=1 at a clock edge): FIFO emptied, accumulator cleared, all outputs 0. Reset has priority over any simultaneous input.
- Push: each cycle, push valid slots in ascending index order, then the trap entry if ex_valid_i=1.
  - Entry fields: pc, op, compressed, taken, trap flag, cause, tval, priv.
  - If free space is less than the number of required pushes, push none of that cycle's entries and set overflow_o. overflow_o clears only on reset.
  - Simultaneous push and pop are allowed; the free-space check uses pre-pop occupancy.
- Pop: one entry per cycle when not empty. Outputs are registered at the pop edge. An instruction presented at edge k appears on the outputs after edge k+1 at the earliest.
- Accumulator: holds start address and halfword count. The start address is latched from the first instruction added when count=0.
- Instruction size: 1 halfword if compressed, else 2.
- Popped OP_OTHER or OP_JAL:
  - Add the instruction to the accumulator; no output.
  - If the new count is 2^IRETIRE_LEN-2 or more, emit a block with itype 0 and clear the accumulator.
- Popped OP_BRANCH, OP_JALR, or OP_ERET:
  - Emit a block: iaddr = start (or this pc if count=0), iretire = count+size, ilastsize = !compressed.
  - itype: taken branch=5, not-taken branch=4, JALR=6, ERET=3.
  - Clear the accumulator.
- Popped trap entry:
  - Emit a block: itype 2 if cause MSB=1, else 1; iretire = count; iaddr = start, or 0 if count=0; ilastsize = the last added instruction's size flag; cause_o/tval_o from the entry.
  - Clear the accumulator.
- valid_o is deasserted in any cycle with no emission. Data outputs hold their last values.
- The downstream consumer is always ready; there is no backpressure input.

Decomposition:
- Package te_connector_pkg holds:
  - XLEN=64, PRIV_LEN=2, ITYPE_LEN=3, IRETIRE_LEN=8, OP_LEN=3.
  - op_class_e: OP_OTHER=0, OP_BRANCH=1, OP_JAL=2, OP_JALR=3, OP_ERET=4.
  - itype_e (values 0..6 as above).
  - The FIFO entry struct.
- One sub-module: te_connector_fifo, a multi-push (up to NRET+1) single-pop FIFO with a free-count output.

Test Plan:
- Reset mid-stream with 5 entries queued -> next cycle all outputs 0, FIFO empty, overflow_o=0.
- Slot0 pc 0x1000 OTHER 32-bit and slot1 pc 0x1004 OTHER compressed, then next cycle slot0 pc 0x1006 BRANCH 32-bit with is_taken_i=1 -> one pulse: iaddr 0x1000, iretire 5, ilastsize 1, itype 5.
- Single JALR compressed at pc 0x2000 with empty accumulator -> iaddr 0x2000, iretire 1, ilastsize 0, itype 6.
- Two 32-bit OTHER instructions from pc 0x3000, then ex_valid_i=1 with cause 0x8000000000000007 and tval 0 -> iretire 4, itype 2, cause_o 0x8000000000000007.
- 127 consecutive 32-bit OTHER instructions -> itype 0 block with iretire 254 at the 127th; accumulator restarts.
- Keep the FIFO full while both slots are valid -> those entries are dropped and overflow_o=1 stays set until reset.

Source files
------------

// File: rtl/te_connector_pkg.sv
// te_connector_pkg: shared types and constants for the CVA6 -> E-trace connector.
// Holds the field widths, the commit op classes, the block termination types,
// the FIFO entry record and the instruction-size helper.
package te_connector_pkg;

    localparam int XLEN        = 64;
    localparam int PRIV_LEN    = 2;
    localparam int ITYPE_LEN   = 3;
    localparam int IRETIRE_LEN = 8;
    localparam int OP_LEN      = 3;

    typedef enum logic [OP_LEN-1:0] {
        OP_OTHER  = 3'd0,
        OP_BRANCH = 3'd1,
        OP_JAL    = 3'd2,
        OP_JALR   = 3'd3,
        OP_ERET   = 3'd4
    } op_class_e;

    typedef enum logic [ITYPE_LEN-1:0] {
        IT_STD    = 3'd0,
        IT_EXC    = 3'd1,
        IT_INT    = 3'd2,
        IT_ERET   = 3'd3,
        IT_NT_BR  = 3'd4,
        IT_TK_BR  = 3'd5,
        IT_UNINF  = 3'd6
    } itype_e;

    // One retired instruction or one trap event, in commit order.
    typedef struct packed {
        logic [XLEN-1:0]     pc;
        op_class_e           op;
        logic                compressed;
        logic                taken;
        logic                trap;
        logic [XLEN-1:0]     cause;
        logic [XLEN-1:0]     tval;
        logic [PRIV_LEN-1:0] priv;
    } entry_t;

    // Halfwords occupied by one instruction.
    function automatic logic [IRETIRE_LEN-1:0] insn_size(input logic compressed);
        return compressed ? 8'd1 : 8'd2;
    endfunction

endpackage

// File: rtl/te_connector_fifo.sv
// te_connector_fifo: multi-push (0..NRET+1 per cycle), single-pop entry FIFO.
// Ports: clk_i/rst_i (sync active-high), push_cnt_i + push_data_i (entries
// packed from index 0), pop_i, head_o (oldest entry), empty_o, free_o (free slots).
// Callers must never push more than free_o entries.
module te_connector_fifo
    import te_connector_pkg::*;
#(
    parameter  int NRET       = 2,
    parameter  int FIFO_DEPTH = 16,
    localparam int PUSH_W     = $clog2(NRET + 2),
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [PUSH_W-1:0] push_cnt_i,
    input  entry_t [NRET:0]   push_data_i,
    input  logic              pop_i,
    output entry_t            head_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  free_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    entry_t           mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             pop_s;

    assign pop_s   = pop_i && (count_r != '0);
    assign empty_o = (count_r == '0);
    assign free_o  = CNT_W'(FIFO_DEPTH) - count_r;
    assign head_o  = mem_r[rd_ptr_r];

    // Storage: write the accepted entries into consecutive slots.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i <= NRET; i++) begin
            if (i < int'(push_cnt_i)) begin
                mem_r[wr_ptr_r + PTR_W'(i)] <= push_data_i[i];
            end
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(push_cnt_i);
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(push_cnt_i) - CNT_W'(pop_s);
        end
    end

endmodule

// File: rtl/te_connector.sv
// te_connector: turns CVA6 commit-port retirements and traps into single-lane
// E-trace instruction blocks. Valid slots (oldest first) and the trap are
// queued each cycle; one entry is popped per cycle and inferable instructions
// are merged until a discontinuity or count saturation emits a block.
// Inputs: clk_i, rst_i, valid_i/pc_i/op_i/is_compressed_i per slot,
//   branch_valid_i/is_taken_i, ex_valid_i/cause_i/tval_i, priv_lvl_i.
// Outputs (registered): valid_o pulse, iretire_o, ilastsize_o, itype_o,
//   cause_o, tval_o, priv_o, iaddr_o, sticky overflow_o.
module te_connector
    import te_connector_pkg::*;
#(
    parameter int NRET       = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NRET-1:0]                   valid_i,
    input  logic [NRET-1:0][XLEN-1:0]         pc_i,
    input  logic [NRET-1:0][OP_LEN-1:0]       op_i,
    input  logic [NRET-1:0]                   is_compressed_i,
    input  logic                              branch_valid_i,
    input  logic                              is_taken_i,
    input  logic                              ex_valid_i,
    input  logic [XLEN-1:0]                   cause_i,
    input  logic [XLEN-1:0]                   tval_i,
    input  logic [PRIV_LEN-1:0]               priv_lvl_i,
    output logic                              valid_o,
    output logic [IRETIRE_LEN-1:0]            iretire_o,
    output logic                              ilastsize_o,
    output logic [ITYPE_LEN-1:0]              itype_o,
    output logic [XLEN-1:0]                   cause_o,
    output logic [XLEN-1:0]                   tval_o,
    output logic [PRIV_LEN-1:0]               priv_o,
    output logic [XLEN-1:0]                   iaddr_o,
    output logic                              overflow_o
);

    localparam int PUSH_W = $clog2(NRET + 2);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    // Flush an inferable run before the next 32-bit instruction could wrap iretire.
    localparam logic [IRETIRE_LEN-1:0] ACC_LIMIT = 8'd254;

    entry_t [NRET:0]          push_data_s;
    logic [PUSH_W-1:0]        req_cnt_s;
    logic [PUSH_W-1:0]        push_cnt_s;
    logic                     accept_s;
    entry_t                   head_s;
    logic                     empty_s;
    logic [CNT_W-1:0]         free_s;

    logic [XLEN-1:0]          acc_addr_r;
    logic [IRETIRE_LEN-1:0]   acc_cnt_r;
    logic                     last_size_r;

    logic                     emit_s;
    logic [XLEN-1:0]          nx_iaddr_s;
    logic [IRETIRE_LEN-1:0]   nx_iretire_s;
    logic                     nx_ilast_s;
    logic [ITYPE_LEN-1:0]     nx_itype_s;
    logic [XLEN-1:0]          nx_cause_s;
    logic [XLEN-1:0]          nx_tval_s;
    logic [PRIV_LEN-1:0]      nx_priv_s;
    logic [XLEN-1:0]          nx_acc_addr_s;
    logic [IRETIRE_LEN-1:0]   nx_acc_cnt_s;
    logic                     nx_last_size_s;
    logic [IRETIRE_LEN-1:0]   sum_s;
    logic [XLEN-1:0]          start_s;

    // Pack this cycle's valid slots (oldest first) followed by the trap entry.
    always_comb begin
        push_data_s = '0;
        req_cnt_s   = '0;
        for (int i = 0; i < NRET; i++) begin
            if (valid_i[i]) begin
                push_data_s[req_cnt_s].pc         = pc_i[i];
                push_data_s[req_cnt_s].op         = op_class_e'(op_i[i]);
                push_data_s[req_cnt_s].compressed = is_compressed_i[i];
                push_data_s[req_cnt_s].taken      = (op_class_e'(op_i[i]) == OP_BRANCH)
                                                    && branch_valid_i && is_taken_i;
                push_data_s[req_cnt_s].priv       = priv_lvl_i;
                req_cnt_s = req_cnt_s + 2'd1;
            end else begin
                req_cnt_s = req_cnt_s;
            end
        end
        if (ex_valid_i) begin
            push_data_s[req_cnt_s].trap  = 1'b1;
            push_data_s[req_cnt_s].cause = cause_i;
            push_data_s[req_cnt_s].tval  = tval_i;
            push_data_s[req_cnt_s].priv  = priv_lvl_i;
            req_cnt_s = req_cnt_s + 2'd1;
        end else begin
            req_cnt_s = req_cnt_s;
        end
    end

    // All-or-nothing admission against pre-pop occupancy.
    assign accept_s   = (free_s >= CNT_W'(req_cnt_s));
    assign push_cnt_s = accept_s ? req_cnt_s : '0;

    te_connector_fifo #(
        .NRET       (NRET),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_cnt_i  (push_cnt_s),
        .push_data_i (push_data_s),
        .pop_i       (!empty_s),
        .head_o      (head_s),
        .empty_o     (empty_s),
        .free_o      (free_s)
    );

    assign sum_s   = acc_cnt_r + insn_size(head_s.compressed);
    assign start_s = (acc_cnt_r == '0) ? head_s.pc : acc_addr_r;

    // Block formation for the popped entry: accumulate or emit.
    always_comb begin
        emit_s         = 1'b0;
        nx_iaddr_s     = iaddr_o;
        nx_iretire_s   = iretire_o;
        nx_ilast_s     = ilastsize_o;
        nx_itype_s     = itype_o;
        nx_cause_s     = cause_o;
        nx_tval_s      = tval_o;
        nx_priv_s      = priv_o;
        nx_acc_addr_s  = acc_addr_r;
        nx_acc_cnt_s   = acc_cnt_r;
        nx_last_size_s = last_size_r;
        if (empty_s) begin
            emit_s = 1'b0;
        end else if (head_s.trap) begin
            // Trap closes the run; the trapping instruction itself is not counted.
            emit_s        = 1'b1;
            nx_iaddr_s    = (acc_cnt_r == '0) ? '0 : acc_addr_r;
            nx_iretire_s  = acc_cnt_r;
            nx_ilast_s    = last_size_r;
            nx_itype_s    = head_s.cause[XLEN-1] ? IT_INT : IT_EXC;
            nx_cause_s    = head_s.cause;
            nx_tval_s     = head_s.tval;
            nx_priv_s     = head_s.priv;
            nx_acc_addr_s = '0;
            nx_acc_cnt_s  = '0;
        end else begin
            nx_last_size_s = !head_s.compressed;
            nx_iaddr_s     = start_s;
            nx_iretire_s   = sum_s;
            nx_ilast_s     = !head_s.compressed;
            nx_cause_s     = '0;
            nx_tval_s      = '0;
            nx_priv_s      = head_s.priv;
            case (head_s.op)
                OP_BRANCH: nx_itype_s = head_s.taken ? IT_TK_BR : IT_NT_BR;
                OP_JALR:   nx_itype_s = IT_UNINF;
                OP_ERET:   nx_itype_s = IT_ERET;
                default:   nx_itype_s = IT_STD;
            endcase
            case (head_s.op)
                OP_BRANCH, OP_JALR, OP_ERET: begin
                    emit_s        = 1'b1;
                    nx_acc_addr_s = '0;
                    nx_acc_cnt_s  = '0;
                end
                default: begin
                    if (sum_s >= ACC_LIMIT) begin
                        emit_s        = 1'b1;
                        nx_acc_addr_s = '0;
                        nx_acc_cnt_s  = '0;
                    end else begin
                        emit_s        = 1'b0;
                        nx_acc_addr_s = start_s;
                        nx_acc_cnt_s  = sum_s;
                    end
                end
            endcase
        end
    end

    // Accumulator, overflow flag and registered block outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_addr_r  <= '0;
            acc_cnt_r   <= '0;
            last_size_r <= 1'b0;
            overflow_o  <= 1'b0;
            valid_o     <= 1'b0;
            iretire_o   <= '0;
            ilastsize_o <= 1'b0;
            itype_o     <= '0;
            cause_o     <= '0;
            tval_o      <= '0;
            priv_o      <= '0;
            iaddr_o     <= '0;
        end else begin
            acc_addr_r  <= nx_acc_addr_s;
            acc_cnt_r   <= nx_acc_cnt_s;
            last_size_r <= nx_last_size_s;
            overflow_o  <= overflow_o | !accept_s;
            valid_o     <= emit_s;
            if (emit_s) begin
                iretire_o   <= nx_iretire_s;
                ilastsize_o <= nx_ilast_s;
                itype_o     <= nx_itype_s;
                cause_o     <= nx_cause_s;
                tval_o      <= nx_tval_s;
                priv_o      <= nx_priv_s;
                iaddr_o     <= nx_iaddr_s;
            end
        end
    end

endmodule

// File: tb/tb_te_connector.sv
// tb_te_connector: directed, table-driven bench for te_connector with
// hand-written sequences for saturation, overflow and mid-stream reset.
module tb_te_connector;
    import te_connector_pkg::*;

    localparam int NRET       = 2;
    localparam int FIFO_DEPTH = 16;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NRET-1:0]             valid;
    logic [NRET-1:0][XLEN-1:0]   pc;
    logic [NRET-1:0][OP_LEN-1:0] op;
    logic [NRET-1:0]             comp;
    logic                        bv, tk, ex;
    logic [XLEN-1:0]             cause, tval;
    logic [PRIV_LEN-1:0]         priv;
    logic                        valid_o, ilastsize_o, overflow_o;
    logic [IRETIRE_LEN-1:0]      iretire_o;
    logic [ITYPE_LEN-1:0]        itype_o;
    logic [XLEN-1:0]             cause_o, tval_o, iaddr_o;
    logic [PRIV_LEN-1:0]         priv_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    te_connector #(.NRET(NRET), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .valid_i         (valid),
        .pc_i            (pc),
        .op_i            (op),
        .is_compressed_i (comp),
        .branch_valid_i  (bv),
        .is_taken_i      (tk),
        .ex_valid_i      (ex),
        .cause_i         (cause),
        .tval_i          (tval),
        .priv_lvl_i      (priv),
        .valid_o         (valid_o),
        .iretire_o       (iretire_o),
        .ilastsize_o     (ilastsize_o),
        .itype_o         (itype_o),
        .cause_o         (cause_o),
        .tval_o          (tval_o),
        .priv_o          (priv_o),
        .iaddr_o         (iaddr_o),
        .overflow_o      (overflow_o)
    );

    typedef struct {
        logic [1:0]  v;
        logic [63:0] pc0, pc1;
        logic [2:0]  op0, op1;
        logic        c0, c1, bv, tk, ex;
        logic [63:0] cs, tv;
        logic        ev;
        logic [63:0] ea;
        logic [7:0]  er;
        logic        el;
        logic [2:0]  et;
        logic [63:0] eca, etv;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] v, input logic [63:0] pc0, input logic [2:0] op0,
                                input logic c0, input logic [63:0] pc1, input logic [2:0] op1,
                                input logic c1, input logic bv_a, input logic tk_a, input logic ex_a,
                                input logic [63:0] cs, input logic [63:0] tv, input logic ev,
                                input logic [63:0] ea, input logic [7:0] er, input logic el,
                                input logic [2:0] et, input logic [63:0] eca, input logic [63:0] etv);
        vec_t r;
        r.v = v; r.pc0 = pc0; r.op0 = op0; r.c0 = c0; r.pc1 = pc1; r.op1 = op1; r.c1 = c1;
        r.bv = bv_a; r.tk = tk_a; r.ex = ex_a; r.cs = cs; r.tv = tv;
        r.ev = ev; r.ea = ea; r.er = er; r.el = el; r.et = et; r.eca = eca; r.etv = etv;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic idle_in();
        valid = 2'b00; pc = '0; op = '0; comp = 2'b00;
        bv = 1'b0; tk = 1'b0; ex = 1'b0; cause = '0; tval = '0; priv = 2'd3;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_block(input string name, input logic [63:0] ea, input logic [7:0] er,
                             input logic el, input logic [2:0] et, input logic [63:0] eca,
                             input logic [63:0] etv);
        chk({name, "_valid"},   64'(valid_o),     64'd1);
        chk({name, "_iaddr"},   iaddr_o,          ea);
        chk({name, "_iretire"}, 64'(iretire_o),   64'(er));
        chk({name, "_ilast"},   64'(ilastsize_o), 64'(el));
        chk({name, "_itype"},   64'(itype_o),     64'(et));
        chk({name, "_cause"},   cause_o,          eca);
        chk({name, "_tval"},    tval_o,           etv);
        chk({name, "_priv"},    64'(priv_o),      64'd3);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_valid"},    64'(valid_o),     64'd0);
        chk({name, "_iaddr"},    iaddr_o,          64'd0);
        chk({name, "_iretire"},  64'(iretire_o),   64'd0);
        chk({name, "_ilast"},    64'(ilastsize_o), 64'd0);
        chk({name, "_itype"},    64'(itype_o),     64'd0);
        chk({name, "_cause"},    cause_o,          64'd0);
        chk({name, "_tval"},     tval_o,           64'd0);
        chk({name, "_priv"},     64'(priv_o),      64'd0);
        chk({name, "_overflow"}, 64'(overflow_o),  64'd0);
    endtask

    vec_t vecs[24];

    initial begin
        int quiet_err;
        idle_in();
        rst = 1'b1;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;

        // Each row: inputs for one edge, then the outputs expected right after it.
        vecs[0]  = mk(2'b11, 64'h1000, OP_OTHER, 1'b0, 64'h1004, OP_OTHER, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 8'd0, 1'b0, 3'd0, 64'h0, 64'h0);
        vecs[1]  = mk(2'b01, 64'h1006, OP_BRANCH, 1'b0, 64'h0, OP_OTHER, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 8'd0, 1'b0, 3'd0, 64'h0, 64'h0);
        vecs[2]  = mk(2'b00, 64'h0, OP_OTHER, 1'b0, 64'h0, OP_OTHER, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 8'd0, 1'b0, 3'd0, 64'h0, 64'h0);
        vecs[3]  = mk(2'b00, 64'h0, OP_OTHER, 1'b0, 64'h0, OP_OTHER, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h1000, 8'd5, 1'b1, 3'd5, 64'h0, 64'h0);
        vecs[4]  = mk(2'b01, 64'h2000, OP_JALR, 1'b1, 64'h0, OP_OTHER, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 8'd0, 1'b0, 3'd0, 64'h0, 64'h0);
        vecs[5]  = mk(2'b00, 64'h0, OP_OTHER, 1'b0, 64'h0, OP_OTHER, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h2000, 8'd1, 1'b0, 3'd6, 64'h0, 64'h0);
        vecs[6]  = mk(2'b11, 64'h3000, OP_OTHER, 1'b0, 64'h3004, OP_OTHER, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 8'd0, 1'b0, 3'd0, 64'h0, 64'h0);
        vecs[7]  = mk(2'b00, 64'h0, OP_OTHER, 1'b0, 64'h0, OP_OTHER, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8000000000000007, 64'h0, 1'b0, 64'h0, 8'd0, 1'b0, 3'd0, 64'h0, 64'h0);
        vecs[8]  = mk(2'b00, 64'h0, OP_OTHER, 1'b0, 64'h0, OP_OTHER, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 8'd0, 1'b0, 3'd0, 64'h0, 64'h0);
        vecs[9]  = mk(2'b00, 64'h0, OP_OTHER, 1'b0, 64'h0, OP_OTHER, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h3000, 8'd4, 1'b1, 3'd2, 64'h8000000000000007, 64'h0);
        vecs[10] = mk(2'b01, 64'h4000, OP_BRANCH, 1'b1, 64'h0, OP_OTHER, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 8'd0, 1'b0, 3'd0, 64'h0, 64'h0);
        vecs[11] = mk(2'b00, 64'h0, OP_OTHER, 1'b0, 64'h0, OP_OTHER, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h4000, 8'd1, 1'b0, 3'd4, 64'h0, 64'h0);
        vecs[12] = mk(2'b01, 64'h5000, OP_ERET, 1'b0, 64'h0, OP_OTHER, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 8'd0, 1'b0, 3'd0, 64'h0, 64'h0);
        vecs[13] = mk(2'b00, 64'h0, OP_OTHER, 1'b0, 64'h0, OP_OTHER, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h5000, 8'd2, 1'b1, 3'd3, 64'h0, 64'h0);
        vecs[14] = mk(2'b00, 64'h0, OP_OTHER, 1'b0, 64'h0, OP_OTHER, 1'b0, 1'b0, 1'b0, 1'b1, 64'h2, 64'hdead, 1'b0, 64'h0, 8'd0, 1'b0, 3'd0, 64'h0, 64'h0);
        vecs[15] = mk(2'b00, 64'h0, OP_OTHER, 1'b0, 64'h0, OP_OTHER, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h0, 8'd0, 1'b1, 3'd1, 64'h2, 64'hdead);
        vecs[16] = mk(2'b11, 64'h6000, OP_JAL, 1'b1, 64'h6002, OP_JALR, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 8'd0, 1'b0, 3'd0, 64'h0, 64'h0);
        vecs[17] = mk(2'b00, 64'h0, OP_OTHER, 1'b0, 64'h0, OP_OTHER, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 8'd0, 1'b0, 3'd0, 64'h0, 64'h0);
        vecs[18] = mk(2'b00, 64'h0, OP_OTHER, 1'b0, 64'h0, OP_OTHER, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h6000, 8'd3, 1'b1, 3'd6, 64'h0, 64'h0);
        vecs[19] = mk(2'b10, 64'h0, OP_OTHER, 1'b0, 64'h7000, OP_BRANCH, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 8'd0, 1'b0, 3'd0, 64'h0, 64'h0);
        vecs[20] = mk(2'b00, 64'h0, OP_OTHER, 1'b0, 64'h0, OP_OTHER, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h7000, 8'd2, 1'b1, 3'd5, 64'h0, 64'h0);
        vecs[21] = mk(2'b01, 64'h8000, OP_OTHER, 1'b1, 64'h0, OP_OTHER, 1'b0, 1'b0, 1'b0, 1'b1, 64'h5, 64'h8000, 1'b0, 64'h0, 8'd0, 1'b0, 3'd0, 64'h0, 64'h0);
        vecs[22] = mk(2'b00, 64'h0, OP_OTHER, 1'b0, 64'h0, OP_OTHER, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 8'd0, 1'b0, 3'd0, 64'h0, 64'h0);
        vecs[23] = mk(2'b00, 64'h0, OP_OTHER, 1'b0, 64'h0, OP_OTHER, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h8000, 8'd1, 1'b0, 3'd1, 64'h5, 64'h8000);

        for (int i = 0; i < 24; i++) begin
            valid = vecs[i].v;
            pc[0] = vecs[i].pc0; pc[1] = vecs[i].pc1;
            op[0] = vecs[i].op0; op[1] = vecs[i].op1;
            comp  = {vecs[i].c1, vecs[i].c0};
            bv = vecs[i].bv; tk = vecs[i].tk; ex = vecs[i].ex;
            cause = vecs[i].cs; tval = vecs[i].tv;
            step();
            if (vecs[i].ev)
                chk_block($sformatf("vec%0d", i), vecs[i].ea, vecs[i].er, vecs[i].el, vecs[i].et, vecs[i].eca, vecs[i].etv);
            else
                chk($sformatf("vec%0d_valid", i), 64'(valid_o), 64'd0);
        end
        idle_in();

        // Saturation: 127 x 32-bit OTHER must close a block at 254 halfwords.
        quiet_err = 0;
        for (int i = 0; i < 127; i++) begin
            valid = 2'b01; op[0] = OP_OTHER; comp = 2'b00;
            pc[0] = 64'h10000 + 64'(4 * i);
            step();
            if (valid_o !== 1'b0) quiet_err++;
        end
        idle_in();
        chk("sat_quiet", 64'(quiet_err), 64'd0);
        step();
        chk_block("sat", 64'h10000, 8'd254, 1'b1, 3'd0, 64'h0, 64'h0);
        valid = 2'b01; op[0] = OP_OTHER; pc[0] = 64'hA000;
        step();
        chk("sat_next_quiet", 64'(valid_o), 64'd0);
        op[0] = OP_JALR; pc[0] = 64'hA004;
        step();
        idle_in();
        step();
        chk_block("sat_restart", 64'hA000, 8'd4, 1'b1, 3'd6, 64'h0, 64'h0);

        // Overflow: two pushes, one pop per cycle; the 15th cycle cannot fit.
        for (int k = 0; k < 15; k++) begin
            valid = 2'b11; op[0] = OP_OTHER; op[1] = OP_OTHER; comp = 2'b00;
            pc[0] = 64'h20000 + 64'(8 * k); pc[1] = 64'h20004 + 64'(8 * k);
            step();
            if (k == 13) chk("ovf_not_yet", 64'(overflow_o), 64'd0);
            if (k == 14) chk("ovf_set", 64'(overflow_o), 64'd1);
        end
        idle_in();
        for (int k = 0; k < 20; k++) step();
        chk("ovf_sticky", 64'(overflow_o), 64'd1);

        // Reset with five entries queued and inputs still active.
        for (int k = 0; k < 4; k++) begin
            valid = 2'b11; op[0] = OP_OTHER; op[1] = OP_OTHER; comp = 2'b00;
            pc[0] = 64'h30000 + 64'(8 * k); pc[1] = 64'h30004 + 64'(8 * k);
            step();
        end
        rst = 1'b1;
        valid = 2'b11; op[0] = OP_BRANCH; op[1] = OP_JALR; bv = 1'b1; tk = 1'b1;
        ex = 1'b1; cause = 64'h3;
        step();
        rst = 1'b0;
        idle_in();
        chk_all_zero("midreset");
        quiet_err = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (valid_o !== 1'b0) quiet_err++;
        end
        chk("midreset_empty", 64'(quiet_err), 64'd0);
        valid = 2'b01; op[0] = OP_JALR; comp = 2'b00; pc[0] = 64'hB000;
        step();
        idle_in();
        step();
        chk_block("post_reset", 64'hB000, 8'd2, 1'b1, 3'd6, 64'h0, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
